writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
Final pipeline stage, directly downstream of the MEM-to-WB pipeline register. It selects the writeback value: the loaded memory data or the ALU/address result. It commits that value into a 32 x N integer register file and serves the two decode-stage read ports, with same-cycle write-to-read bypass. It also keeps a retired-write counter for debug and performance use.

Parameters:
N, 64, datapath and register width in bits
CNT_W, 32, width of the retired-write counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low (0 = reset asserted, sampled on rising clk)
memToReg  input  1  1 = write back dataMem, 0 = write back addressMem (from MEM-to-WB register)
regWrite  input  1  writeback enable
writeReg  input  5  destination register index
addressMem  input  N  ALU/address result
dataMem  input  N  data loaded from memory
readReg1  input  5  decode-stage source index 1
readReg2  input  5  decode-stage source index 2
readData1  output  N  value of readReg1
readData2  output  N  value of readReg2
writeData  output  N  selected writeback value, fed to the EX forwarding mux
wbCount  output  CNT_W  number of committed register writes since reset

Behaviour:
- writeData is combinational: memToReg ? dataMem : addressMem. It is valid whatever regWrite is.
- Commit condition: rst==1 && regWrite==1 && writeReg!=0. On the rising clk edge, regs[writeReg] <= writeData.
- Register x0 is hardwired to zero. Writes to index 0 are discarded, do not count, and are never bypassed. Reads of index 0 always return 0.
- Reads are combinational, with write-through bypass. readDataK = 0 if readRegK==0. Otherwise, if the commit condition holds and writeReg==readRegK, readDataK = writeData (same-cycle value). Otherwise readDataK = regs[readRegK].
- Both read ports may address the same register, or the register being written. Each port resolves independently and identically.
- wbCount increments by 1 on every committed write. It wraps from 2^CNT_W-1 to 0 with no flag.
- Reset (rst==0 at a rising edge):
  - all 31 registers clear to 0 and wbCount clears to 0;
  - any write presented in that cycle is dropped and not counted.
- While rst==0, bypass is suppressed, so reads return 0, the post-reset register value.
- Reset asserted in the middle of a write stream: the first edge with rst==0 wins over a pending write. The first write with rst==1 commits normally.
- Latency:
  - writeData and bypass: 0 cycles, combinational;
  - register content visible through the array: the cycle after the commit edge;
  - wbCount update: 1 cycle.
- No X propagation: every register has a defined value after the first reset edge.

Decomposition:
- Shared package (riscv_pkg): REG_COUNT=32, REG_IDX_W=5, ZERO_REG=5'd0, and a typedef reg_idx_t = logic [4:0].
- One natural sub-module, regfile_2r1w: the 32 x N array with synchronous active-low clear, the x0 rule and bypass.
- The top-level writeback_stage holds the writeback mux and the wbCount counter, and instantiates regfile_2r1w.

Test Plan:
- Reset then read: hold rst=0 for 2 cycles, then rst=1, readReg1=5, readReg2=31 -> readData1=0, readData2=0, wbCount=0.
- Mux and commit:
  - memToReg=0, addressMem=64'h1234, regWrite=1, writeReg=3 for one cycle -> writeData=64'h1234, and next cycle readReg1=3 gives 64'h1234, wbCount=1.
  - Then memToReg=1, dataMem=64'hDEAD_BEEF, writeReg=4 -> x4=64'hDEAD_BEEF, wbCount=2.
- Bypass: regWrite=1, writeReg=7, addressMem=64'hAA, readReg1=readReg2=7 in the same cycle -> both read ports show 64'hAA before the edge. With regWrite=0 they show the old x7 value instead.
- x0 immunity: regWrite=1, writeReg=0, addressMem=64'hFFFF, readReg1=0 -> readData1=0 in the same cycle and the next, and wbCount unchanged.
- Reset mid-stream: write x9=64'h55 and commit it, then present a write x9=64'h66 together with rst=0 -> after the edge x9=0, wbCount=0. The next write x9=64'h77 with rst=1 -> x9=64'h77, wbCount=1.
- Counter wrap: CNT_W=4, perform 17 committed writes to x1 -> wbCount reads 1, and x1 holds the last written value.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared register-file constants and index type for the RISC-V pipeline slice.
package riscv_pkg;

  localparam int REG_COUNT = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = 5'd0;

endpackage

// File: rtl/regfile_2r1w.sv
// 32 x N integer register file: two combinational read ports with write-through
// bypass, one synchronous write port, synchronous active-low clear, x0 hardwired to zero.
module regfile_2r1w
  import riscv_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  reg_idx_t     waddr,
  input  logic [N-1:0] wdata,
  input  reg_idx_t     raddr1,
  input  reg_idx_t     raddr2,
  output logic [N-1:0] rdata1,
  output logic [N-1:0] rdata2
);

  logic [N-1:0] regs [REG_COUNT];
  logic         commit;

  assign commit = rst && we && (waddr != ZERO_REG);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[waddr] <= wdata;
    end
  end

  // While reset is held, reads report the post-reset value rather than stale contents.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (rst) begin
      if (raddr1 != ZERO_REG) begin
        rdata1 = (commit && (waddr == raddr1)) ? wdata : regs[raddr1];
      end
      if (raddr2 != ZERO_REG) begin
        rdata2 = (commit && (waddr == raddr2)) ? wdata : regs[raddr2];
      end
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: selects the writeback value, commits it into the register
// file, serves the decode read ports and counts retired register writes.
module writeback_stage
  import riscv_pkg::*;
#(
  parameter int N     = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memToReg,
  input  logic             regWrite,
  input  reg_idx_t         writeReg,
  input  logic [N-1:0]     addressMem,
  input  logic [N-1:0]     dataMem,
  input  reg_idx_t         readReg1,
  input  reg_idx_t         readReg2,
  output logic [N-1:0]     readData1,
  output logic [N-1:0]     readData2,
  output logic [N-1:0]     writeData,
  output logic [CNT_W-1:0] wbCount
);

  logic commit;

  assign writeData = memToReg ? dataMem : addressMem;
  assign commit    = rst && regWrite && (writeReg != ZERO_REG);

  // Free-running retired-write counter; wraps silently.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wbCount <= '0;
    end else if (commit) begin
      wbCount <= wbCount + CNT_W'(1);
    end
  end

  regfile_2r1w #(
    .N(N)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (regWrite),
    .waddr (writeReg),
    .wdata (writeData),
    .raddr1(readReg1),
    .raddr2(readReg2),
    .rdata1(readData1),
    .rdata2(readData2)
  );

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed vector table, randomized
// run against a behavioural model, and a counter-wrap sequence on a narrow counter.
module tb_writeback_stage;

  logic        clk;
  logic        rst;
  logic        memToReg;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [63:0] addressMem;
  logic [63:0] dataMem;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [63:0] readData1;
  logic [63:0] readData2;
  logic [63:0] writeData;
  logic [31:0] wbCount;

  logic        w_memToReg;
  logic        w_regWrite;
  logic [4:0]  w_writeReg;
  logic [63:0] w_addressMem;
  logic [63:0] w_dataMem;
  logic [4:0]  w_readReg1;
  logic [4:0]  w_readReg2;
  logic [63:0] w_readData1;
  logic [63:0] w_readData2;
  logic [63:0] w_writeData;
  logic [3:0]  w_wbCount;

  int checks;
  int failures;

  logic [63:0] model_regs [32];
  logic [31:0] model_cnt;

  typedef struct {
    logic        rst;
    logic        mem_to_reg;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [63:0] address_mem;
    logic [63:0] data_mem;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [63:0] exp_wd;
    logic [63:0] exp_rd1;
    logic [63:0] exp_rd2;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs [11];

  writeback_stage #(.N(64), .CNT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .memToReg  (memToReg),
    .regWrite  (regWrite),
    .writeReg  (writeReg),
    .addressMem(addressMem),
    .dataMem   (dataMem),
    .readReg1  (readReg1),
    .readReg2  (readReg2),
    .readData1 (readData1),
    .readData2 (readData2),
    .writeData (writeData),
    .wbCount   (wbCount)
  );

  writeback_stage #(.N(64), .CNT_W(4)) dut_wrap (
    .clk       (clk),
    .rst       (rst),
    .memToReg  (w_memToReg),
    .regWrite  (w_regWrite),
    .writeReg  (w_writeReg),
    .addressMem(w_addressMem),
    .dataMem   (w_dataMem),
    .readReg1  (w_readReg1),
    .readReg2  (w_readReg2),
    .readData1 (w_readData1),
    .readData2 (w_readData2),
    .writeData (w_writeData),
    .wbCount   (w_wbCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic m, input logic w,
                              input logic [4:0] wr, input logic [63:0] a,
                              input logic [63:0] d, input logic [4:0] r1,
                              input logic [4:0] r2, input logic [63:0] ewd,
                              input logic [63:0] e1, input logic [63:0] e2,
                              input logic [31:0] ec);
    vec_t v;
    v.rst = r; v.mem_to_reg = m; v.reg_write = w; v.write_reg = wr;
    v.address_mem = a; v.data_mem = d; v.read_reg1 = r1; v.read_reg2 = r2;
    v.exp_wd = ewd; v.exp_rd1 = e1; v.exp_rd2 = e2; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic m, input logic w,
                               input logic [4:0] wr, input logic [63:0] a,
                               input logic [63:0] d, input logic [4:0] r1,
                               input logic [4:0] r2);
    rst = r; memToReg = m; regWrite = w; writeReg = wr;
    addressMem = a; dataMem = d; readReg1 = r1; readReg2 = r2;
  endtask

  task automatic doReset();
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 5'd0, 5'd0);
    w_regWrite = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) model_regs[i] = 64'd0;
    model_cnt = 32'd0;
  endtask

  // Reference read: reset forces zero, x0 is zero, a committing write is seen immediately.
  function automatic logic [63:0] modelRead(input logic [4:0] idx);
    logic [63:0] wd;
    logic        commit;
    wd     = memToReg ? dataMem : addressMem;
    commit = rst && regWrite && (writeReg != 5'd0);
    if (!rst || idx == 5'd0) return 64'd0;
    if (commit && writeReg == idx) return wd;
    return model_regs[idx];
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    w_memToReg = 1'b0; w_regWrite = 1'b0; w_writeReg = 5'd0;
    w_addressMem = 64'd0; w_dataMem = 64'd0; w_readReg1 = 5'd0; w_readReg2 = 5'd0;

    vecs[0]  = mk(1, 0, 1, 3, 64'h1234, 64'h0, 5, 31, 64'h1234, 64'h0, 64'h0, 0);
    vecs[1]  = mk(1, 1, 1, 4, 64'h0, 64'hDEAD_BEEF, 3, 4, 64'hDEAD_BEEF, 64'h1234, 64'hDEAD_BEEF, 1);
    vecs[2]  = mk(1, 0, 1, 7, 64'hAA, 64'h0, 7, 7, 64'hAA, 64'hAA, 64'hAA, 2);
    vecs[3]  = mk(1, 0, 0, 7, 64'hBB, 64'h0, 7, 4, 64'hBB, 64'hAA, 64'hDEAD_BEEF, 3);
    vecs[4]  = mk(1, 0, 1, 0, 64'hFFFF, 64'h0, 0, 0, 64'hFFFF, 64'h0, 64'h0, 3);
    vecs[5]  = mk(1, 0, 0, 0, 64'h0, 64'h0, 0, 3, 64'h0, 64'h0, 64'h1234, 3);
    vecs[6]  = mk(1, 0, 1, 9, 64'h55, 64'h0, 9, 9, 64'h55, 64'h55, 64'h55, 3);
    vecs[7]  = mk(0, 0, 1, 9, 64'h66, 64'h0, 9, 3, 64'h66, 64'h0, 64'h0, 4);
    vecs[8]  = mk(1, 0, 0, 9, 64'h0, 64'h0, 9, 3, 64'h0, 64'h0, 64'h0, 0);
    vecs[9]  = mk(1, 0, 1, 9, 64'h77, 64'h0, 9, 9, 64'h77, 64'h77, 64'h77, 0);
    vecs[10] = mk(1, 1, 0, 9, 64'h0, 64'h123, 9, 0, 64'h123, 64'h77, 64'h0, 1);

    doReset();
    for (int i = 0; i < 11; i++) begin
      if (i != 0) @(negedge clk);
      applyStimulus(vecs[i].rst, vecs[i].mem_to_reg, vecs[i].reg_write, vecs[i].write_reg,
                    vecs[i].address_mem, vecs[i].data_mem, vecs[i].read_reg1, vecs[i].read_reg2);
      #1;
      checkOutput($sformatf("vec%0d writeData", i), writeData, vecs[i].exp_wd);
      checkOutput($sformatf("vec%0d readData1", i), readData1, vecs[i].exp_rd1);
      checkOutput($sformatf("vec%0d readData2", i), readData2, vecs[i].exp_rd2);
      checkOutput($sformatf("vec%0d wbCount", i), {32'd0, wbCount}, {32'd0, vecs[i].exp_cnt});
    end

    // Randomized traffic against the behavioural model, with occasional reset pulses.
    doReset();
    for (int c = 0; c < 400; c++) begin
      logic [4:0] wr;
      @(negedge clk);
      wr = 5'($urandom_range(0, 7));
      applyStimulus(($urandom_range(0, 19) != 0), 1'($urandom), 1'($urandom), wr,
                    {$urandom, $urandom}, {$urandom, $urandom},
                    ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 7)),
                    ($urandom_range(0, 2) == 0) ? wr : 5'($urandom));
      #1;
      checkOutput("rand writeData", writeData, memToReg ? dataMem : addressMem);
      checkOutput("rand readData1", readData1, modelRead(readReg1));
      checkOutput("rand readData2", readData2, modelRead(readReg2));
      checkOutput("rand wbCount", {32'd0, wbCount}, {32'd0, model_cnt});
      @(posedge clk);
      if (!rst) begin
        for (int i = 0; i < 32; i++) model_regs[i] = 64'd0;
        model_cnt = 32'd0;
      end else if (regWrite && writeReg != 5'd0) begin
        model_regs[writeReg] = memToReg ? dataMem : addressMem;
        model_cnt = model_cnt + 32'd1;
      end
    end

    // Narrow counter: 17 commits to x1 wrap a 4-bit count to 1.
    doReset();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      w_regWrite = 1'b1; w_writeReg = 5'd1; w_addressMem = 64'(100 + i);
      w_readReg1 = 5'd2; w_readReg2 = 5'd0;
      if (i == 16) begin
        #1;
        checkOutput("wrap count16", {60'd0, w_wbCount}, 64'd0);
      end
    end
    @(negedge clk);
    w_regWrite = 1'b0; w_readReg1 = 5'd1;
    #1;
    checkOutput("wrap count17", {60'd0, w_wbCount}, 64'd1);
    checkOutput("wrap x1", w_readData1, 64'd116);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
